// File: rtl/alu_counter_decode_pkg.sv
// Shared constants for the ECLair execution-unit helper block.
//   ALU mode encodings, named 74181-style op selects, ALU datapath width,
//   and a one-hot decode helper used by the strobe decoder.
package alu_counter_decode_pkg;

  localparam int unsigned ALU_W = 16;

  localparam logic ALU_MODE_ARITH = 1'b0;
  localparam logic ALU_MODE_LOGIC = 1'b1;

  // Arithmetic-mode op selects
  localparam logic [3:0] OP_ADD    = 4'h9;
  localparam logic [3:0] OP_SUB    = 4'h6;  // A-B-1, or A-B with c_in=1
  localparam logic [3:0] OP_INC_A  = 4'h0;  // A + c_in
  localparam logic [3:0] OP_DEC_A  = 4'hF;  // A - 1 + c_in
  localparam logic [3:0] OP_DBL_A  = 4'hC;  // A + A

  // Logic-mode op selects
  localparam logic [3:0] OP_PASS_A = 4'hF;
  localparam logic [3:0] OP_PASS_B = 4'hA;
  localparam logic [3:0] OP_XOR    = 4'h6;
  localparam logic [3:0] OP_AND    = 4'hB;
  localparam logic [3:0] OP_OR     = 4'hE;
  localparam logic [3:0] OP_NOT_A  = 4'h0;
  localparam logic [3:0] OP_ZERO   = 4'h3;
  localparam logic [3:0] OP_ONES   = 4'hC;

  // 3-to-8 one-hot decode
  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    logic [7:0] v;
    v = 8'b0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/alu_core_181.sv
// Combinational 16-bit ALU in 74181 style.
//   mode_i  : 0 = arithmetic, 1 = logic
//   op_i    : operation select S[3:0]
//   c_in_i  : active-high carry in (arithmetic only)
//   a_i/b_i : operands
//   z_o     : result
//   c_out_o : carry out of the top bit, forced 0 in logic mode
module alu_core_181
  import alu_counter_decode_pkg::*;
(
  input  logic             mode_i,
  input  logic [3:0]       op_i,
  input  logic             c_in_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] z_o,
  output logic             c_out_o
);

  logic [ALU_W-1:0] u, v, logic_z;
  logic [ALU_W:0]   sum;

  // Arithmetic operand pair: result is u + v + c_in
  always_comb begin
    u = a_i;
    v = '0;
    unique case (op_i)
      4'h0: begin u = a_i;         v = '0;         end
      4'h1: begin u = a_i | b_i;   v = '0;         end
      4'h2: begin u = a_i | ~b_i;  v = '0;         end
      4'h3: begin u = '0;          v = '1;         end
      4'h4: begin u = a_i;         v = a_i & ~b_i; end
      4'h5: begin u = a_i | b_i;   v = a_i & ~b_i; end
      4'h6: begin u = a_i;         v = ~b_i;       end
      4'h7: begin u = a_i & ~b_i;  v = '1;         end
      4'h8: begin u = a_i;         v = a_i & b_i;  end
      4'h9: begin u = a_i;         v = b_i;        end
      4'hA: begin u = a_i | ~b_i;  v = a_i & b_i;  end
      4'hB: begin u = a_i & b_i;   v = '1;         end
      4'hC: begin u = a_i;         v = a_i;        end
      4'hD: begin u = a_i | b_i;   v = a_i;        end
      4'hE: begin u = a_i | ~b_i;  v = a_i;        end
      4'hF: begin u = a_i;         v = '1;         end
      default: begin u = 'x;       v = 'x;         end
    endcase
  end

  assign sum = {1'b0, u} + {1'b0, v} + {{ALU_W{1'b0}}, c_in_i};

  always_comb begin
    logic_z = '0;
    unique case (op_i)
      4'h0: logic_z = ~a_i;
      4'h1: logic_z = ~(a_i | b_i);
      4'h2: logic_z = ~a_i & b_i;
      4'h3: logic_z = '0;
      4'h4: logic_z = ~(a_i & b_i);
      4'h5: logic_z = ~b_i;
      4'h6: logic_z = a_i ^ b_i;
      4'h7: logic_z = a_i & ~b_i;
      4'h8: logic_z = ~a_i | b_i;
      4'h9: logic_z = ~(a_i ^ b_i);
      4'hA: logic_z = b_i;
      4'hB: logic_z = a_i & b_i;
      4'hC: logic_z = '1;
      4'hD: logic_z = a_i | ~b_i;
      4'hE: logic_z = a_i | b_i;
      4'hF: logic_z = a_i;
      default: logic_z = 'x;
    endcase
  end

  assign z_o     = (mode_i == ALU_MODE_LOGIC) ? logic_z : sum[ALU_W-1:0];
  assign c_out_o = (mode_i == ALU_MODE_LOGIC) ? 1'b0 : sum[ALU_W];

endmodule

// File: rtl/alu_counter_decode.sv
// ECLair execution-unit helper: 74181-style ALU, loadable up-counter and
// 3-to-8 one-hot strobe decoder.
//   clk, _reset            : clock, async active-low reset (counter only)
//   alu_mode/alu_op/c_in   : ALU control
//   x, y -> z, c_out, zero : ALU datapath
//   ctr_load/ctr_en/ctr_preset -> ctr_out : counter (load beats enable)
//   dmx_sel -> dmx_out     : one-hot decode, independent of reset
module alu_counter_decode
  import alu_counter_decode_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 _reset,
  input  logic                 alu_mode,
  input  logic [3:0]           alu_op,
  input  logic                 c_in,
  input  logic [ALU_W-1:0]     x,
  input  logic [ALU_W-1:0]     y,
  output logic [ALU_W-1:0]     z,
  output logic                 c_out,
  output logic                 zero,
  input  logic                 ctr_load,
  input  logic                 ctr_en,
  input  logic [CTR_WIDTH-1:0] ctr_preset,
  output logic [CTR_WIDTH-1:0] ctr_out,
  input  logic [2:0]           dmx_sel,
  output logic [7:0]           dmx_out
);

  alu_core_181 u_alu (
    .mode_i  (alu_mode),
    .op_i    (alu_op),
    .c_in_i  (c_in),
    .a_i     (x),
    .b_i     (y),
    .z_o     (z),
    .c_out_o (c_out)
  );

  assign zero = (z == '0);

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (ctr_load) begin
      ctr_d = ctr_preset;
    end else if (ctr_en) begin
      ctr_d = ctr_q + {{(CTR_WIDTH-1){1'b0}}, 1'b1};  // wraps silently
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_out = ctr_q;
  assign dmx_out = onehot8(dmx_sel);

endmodule

// File: tb/tb_alu_counter_decode.sv
module tb_alu_counter_decode;

  logic        clk;
  logic        rst_n;
  logic        alu_mode;
  logic [3:0]  alu_op;
  logic        c_in;
  logic [15:0] x, y;
  logic        ctr_load, ctr_en;
  logic [15:0] preset16;
  logic [7:0]  preset8;
  logic [2:0]  dmx_sel;

  logic [15:0] z16, z8;
  logic        c16, c8, zero16, zero8;
  logic [15:0] ctr16;
  logic [7:0]  ctr8;
  logic [7:0]  dmx16, dmx8;

  int total = 0;
  int bad   = 0;
  int m16, m8;  // counter reference values

  alu_counter_decode #(.CTR_WIDTH(16)) dut16 (
    .clk(clk), ._reset(rst_n), .alu_mode(alu_mode), .alu_op(alu_op), .c_in(c_in),
    .x(x), .y(y), .z(z16), .c_out(c16), .zero(zero16),
    .ctr_load(ctr_load), .ctr_en(ctr_en), .ctr_preset(preset16), .ctr_out(ctr16),
    .dmx_sel(dmx_sel), .dmx_out(dmx16)
  );

  alu_counter_decode #(.CTR_WIDTH(8)) dut8 (
    .clk(clk), ._reset(rst_n), .alu_mode(alu_mode), .alu_op(alu_op), .c_in(c_in),
    .x(x), .y(y), .z(z8), .c_out(c8), .zero(zero8),
    .ctr_load(ctr_load), .ctr_en(ctr_en), .ctr_preset(preset8), .ctr_out(ctr8),
    .dmx_sel(dmx_sel), .dmx_out(dmx8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU taken straight from the operation tables.
  function automatic void alu_ref(input bit mode, input bit [3:0] op, input bit cin,
                                  input bit [15:0] a, input bit [15:0] b,
                                  output bit [15:0] r, output bit co);
    bit [15:0] uu, vv;
    bit [16:0] s;
    if (mode) begin
      case (op)
        4'h0: r = ~a;        4'h1: r = ~(a | b);  4'h2: r = ~a & b;    4'h3: r = 16'h0000;
        4'h4: r = ~(a & b);  4'h5: r = ~b;        4'h6: r = a ^ b;     4'h7: r = a & ~b;
        4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);  4'hA: r = b;         4'hB: r = a & b;
        4'hC: r = 16'hFFFF;  4'hD: r = a | ~b;    4'hE: r = a | b;     default: r = a;
      endcase
      co = 1'b0;
    end else begin
      case (op)
        4'h0: begin uu = a;      vv = 16'h0;    end
        4'h1: begin uu = a | b;  vv = 16'h0;    end
        4'h2: begin uu = a | ~b; vv = 16'h0;    end
        4'h3: begin uu = 16'h0;  vv = 16'hFFFF; end
        4'h4: begin uu = a;      vv = a & ~b;   end
        4'h5: begin uu = a | b;  vv = a & ~b;   end
        4'h6: begin uu = a;      vv = ~b;       end
        4'h7: begin uu = a & ~b; vv = 16'hFFFF; end
        4'h8: begin uu = a;      vv = a & b;    end
        4'h9: begin uu = a;      vv = b;        end
        4'hA: begin uu = a | ~b; vv = a & b;    end
        4'hB: begin uu = a & b;  vv = 16'hFFFF; end
        4'hC: begin uu = a;      vv = a;        end
        4'hD: begin uu = a | b;  vv = a;        end
        4'hE: begin uu = a | ~b; vv = a;        end
        default: begin uu = a;   vv = 16'hFFFF; end
      endcase
      s  = 17'(uu) + 17'(vv) + 17'(cin);
      r  = s[15:0];
      co = s[16];
    end
  endfunction

  task automatic alu_dir(input string tag, input bit mode, input bit [3:0] op, input bit cin,
                         input bit [15:0] a, input bit [15:0] b,
                         input bit [15:0] ez, input bit ec);
    alu_mode = mode; alu_op = op; c_in = cin; x = a; y = b;
    #1;
    check({tag, ".z"}, 32'(z16), 32'(ez));
    check({tag, ".c"}, 32'(c16), 32'(ec));
    check({tag, ".zero"}, 32'(zero16), 32'(ez == 16'h0));
  endtask

  // One rising edge: advance the counter model, then sample just after.
  task automatic tick(input string tag);
    @(posedge clk);
    if (ctr_load) begin
      m16 = int'(preset16);
      m8  = int'(preset8);
    end else if (ctr_en) begin
      m16 = (m16 + 1) % 65536;
      m8  = (m8 + 1) % 256;
    end
    #1;
    check({tag, ".ctr16"}, 32'(ctr16), 32'(m16));
    check({tag, ".ctr8"}, 32'(ctr8), 32'(m8));
  endtask

  initial begin
    bit [15:0] rz;
    bit        rc;
    rst_n = 1'b0; alu_mode = 1'b0; alu_op = 4'h0; c_in = 1'b0; x = '0; y = '0;
    ctr_load = 1'b0; ctr_en = 1'b0; preset16 = '0; preset8 = '0; dmx_sel = 3'd5;
    m16 = 0; m8 = 0;
    #2;
    check("rst.ctr16", 32'(ctr16), 32'h0);
    check("rst.ctr8", 32'(ctr8), 32'h0);
    check("rst.dmx", 32'(dmx16), 32'h20);

    // Directed ALU cases
    alu_dir("add",     1'b0, 4'h9, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
    alu_dir("add_wrap",1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    alu_dir("sub_c1",  1'b0, 4'h6, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1);
    alu_dir("sub_c0",  1'b0, 4'h6, 1'b0, 16'h0005, 16'h0003, 16'h0001, 1'b1);
    alu_dir("sub_neg", 1'b0, 4'h6, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    alu_dir("xor",     1'b1, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0);
    alu_dir("xor_cin", 1'b1, 4'h6, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0);
    alu_dir("and",     1'b1, 4'hB, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
    alu_dir("or",      1'b1, 4'hE, 1'b1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0);
    alu_dir("nota",    1'b1, 4'h0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0);
    alu_dir("zero",    1'b1, 4'h3, 1'b1, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0);
    alu_dir("passb",   1'b1, 4'hA, 1'b0, 16'hF0F0, 16'hFF00, 16'hFF00, 1'b0);

    // Random ALU vectors against the table model
    for (int i = 0; i < 200; i++) begin
      alu_mode = 1'($urandom);
      alu_op   = 4'($urandom);
      c_in     = 1'($urandom);
      x        = 16'($urandom);
      y        = (i % 10 == 0) ? ~x : 16'($urandom);
      #1;
      alu_ref(alu_mode, alu_op, c_in, x, y, rz, rc);
      check("rnd.z", 32'(z16), 32'(rz));
      check("rnd.c", 32'(c16), 32'(rc));
      check("rnd.zero", 32'(zero16), 32'(rz == 16'h0));
      check("rnd.z8", 32'(z8), 32'(rz));
    end

    // Decoder sweep, held in reset for the first half
    for (int i = 0; i < 8; i++) begin
      dmx_sel = 3'(i);
      #1;
      check("dmx", 32'(dmx16), 32'(8'h01 << i));
      check("dmx8", 32'(dmx8), 32'(8'h01 << i));
      if (i == 3) rst_n = 1'b1;
    end

    // Count to 7, then asynchronous reset between edges
    @(negedge clk);
    ctr_en = 1'b1;
    for (int i = 0; i < 7; i++) tick("cnt7");
    check("cnt7.val", 32'(ctr16), 32'h7);
    rst_n = 1'b0;
    m16 = 0; m8 = 0;
    #1;
    check("async_rst", 32'(ctr16), 32'h0);
    check("async_rst8", 32'(ctr8), 32'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("cnt3");
    check("cnt3.val", 32'(ctr16), 32'h3);
    ctr_en = 1'b0;
    tick("hold");
    tick("hold");

    // Load beats enable, then wrap
    ctr_load = 1'b1; ctr_en = 1'b1; preset16 = 16'hFFFF; preset8 = 8'hFE;
    tick("load");
    check("load.val", 32'(ctr16), 32'hFFFF);
    ctr_load = 1'b0;
    tick("wrap");
    check("wrap.val", 32'(ctr16), 32'h0);
    tick("wrap8");
    check("wrap8.val", 32'(ctr8), 32'h0);

    // Random counter traffic
    for (int i = 0; i < 60; i++) begin
      ctr_load = ($urandom_range(0, 5) == 0);
      ctr_en   = 1'($urandom);
      preset16 = (i % 7 == 0) ? 16'hFFFE : 16'($urandom);
      preset8  = (i % 7 == 0) ? 8'hFE : 8'($urandom);
      tick("rnd_ctr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
